// File: rtl/mem_slot_arbiter_if.sv
// Bus bundle for the memory-slot arbiter: CPU port, video port and RAM port.
// Both requesters use req/ack: req is held until a one-cycle ack; ack may be followed by a new req next cycle.
`default_nettype none

interface mem_slot_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  vid_req, vid_addr,
        output vid_rdata, vid_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output vid_req, vid_addr,
        input  vid_rdata, vid_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_slot_arbiter.sv
// Time-multiplexes the shared RAM between CPU and video, one slot per mem_phi rising edge.
// Optional slot statistics outputs are enabled with MEM_SLOT_STATS_EN.
`default_nettype none

module mem_slot_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  wire logic           CLOCK_50,
    input  wire logic           reset,
    input  wire logic           cpu_phi,
    input  wire logic           mem_phi,
    input  wire logic           vid_phi,
    mem_slot_arbiter_if.slave   bus,
    output logic [1:0]          state_dbg
`ifdef MEM_SLOT_STATS_EN
    ,
    output logic [7:0]          cpu_slots,
    output logic [7:0]          vid_slots,
    output logic [7:0]          missed_slots
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic              mem_phi_q;
    logic              owner_vid;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vid_rdata_q;

    logic slot_start;
    logic own_cpu;
    logic own_vid;
    logic start_cpu;
    logic start_vid;

    always_comb begin
        slot_start = mem_phi & ~mem_phi_q;
        own_cpu    = cpu_phi & ~vid_phi;
        own_vid    = ~cpu_phi & vid_phi;
        // A slot that opens while busy is dropped, so starts are only taken from IDLE.
        start_cpu  = slot_start & (state == S_IDLE) & own_cpu & bus.cpu_req;
        start_vid  = slot_start & (state == S_IDLE) & own_vid & bus.vid_req;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mem_phi_q   <= 1'b1;
            state       <= S_IDLE;
            owner_vid   <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_we      <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            mem_phi_q <= mem_phi;
            case (state)
                S_IDLE: begin
                    if (start_cpu) begin
                        owner_vid <= 1'b0;
                        lat_addr  <= bus.cpu_addr;
                        lat_wdata <= bus.cpu_wdata;
                        lat_we    <= bus.cpu_we;
                        state     <= S_ISSUE;
                    end else if (start_vid) begin
                        owner_vid <= 1'b1;
                        lat_addr  <= bus.vid_addr;
                        lat_we    <= 1'b0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (!lat_we) begin
                        if (owner_vid) vid_rdata_q <= bus.mem_rdata;
                        else           cpu_rdata_q <= bus.mem_rdata;
                    end
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write data is left untouched by video slots so mem_wdata keeps its last value.
    always_comb begin
        bus.mem_en    = (state == S_ISSUE);
        bus.mem_we    = (state == S_ISSUE) & lat_we;
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
        bus.cpu_ack   = (state == S_DONE) & ~owner_vid;
        bus.vid_ack   = (state == S_DONE) & owner_vid;
        bus.cpu_rdata = cpu_rdata_q;
        bus.vid_rdata = vid_rdata_q;
        state_dbg     = state;
    end

`ifdef MEM_SLOT_STATS_EN
    logic missed_ev;

    always_comb begin
        missed_ev = slot_start & ((state != S_IDLE) | ~(own_cpu | own_vid));
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cpu_slots    <= 8'd0;
            vid_slots    <= 8'd0;
            missed_slots <= 8'd0;
        end else begin
            if (bus.cpu_ack && cpu_slots != 8'hFF)   cpu_slots    <= cpu_slots + 8'd1;
            if (bus.vid_ack && vid_slots != 8'hFF)   vid_slots    <= vid_slots + 8'd1;
            if (missed_ev && missed_slots != 8'hFF) missed_slots <= missed_slots + 8'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_slot_arbiter.sv
// Directed bench for mem_slot_arbiter: reads, writes, alternation, late request, reset and dropped slots.
`timescale 1ns/1ps

module tb_mem_slot_arbiter;

  logic CLOCK_50;
  logic reset;
  logic cpu_phi;
  logic mem_phi;
  logic vid_phi;
  logic [1:0] state_dbg;
`ifdef MEM_SLOT_STATS_EN
  logic [7:0] cpu_slots;
  logic [7:0] vid_slots;
  logic [7:0] missed_slots;
`endif

  mem_slot_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_slot_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .cpu_phi  (cpu_phi),
    .mem_phi  (mem_phi),
    .vid_phi  (vid_phi),
    .bus      (bus),
    .state_dbg(state_dbg)
`ifdef MEM_SLOT_STATS_EN
    ,
    .cpu_slots   (cpu_slots),
    .vid_slots   (vid_slots),
    .missed_slots(missed_slots)
`endif
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // RAM model: read data valid exactly one cycle after a read strobe, garbage otherwise
  logic [7:0] ram [0:65535];
  always @(posedge CLOCK_50) begin
    if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr] : 8'hEE;
  end

  // event monitor, sampled on the inactive edge
  int en_cnt;
  int cpu_ack_cnt;
  int vid_ack_cnt;
  int both_ack_cnt;
  always @(negedge CLOCK_50) begin
    if (bus.mem_en) en_cnt++;
    if (bus.cpu_ack) cpu_ack_cnt++;
    if (bus.vid_ack) vid_ack_cnt++;
    if (bus.cpu_ack && bus.vid_ack) both_ack_cnt++;
  end

  int tests;
  int fails;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic clr_counts();
    en_cnt = 0;
    cpu_ack_cnt = 0;
    vid_ack_cnt = 0;
    both_ack_cnt = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clr_counts();
    ram[16'h1234] = 8'hA5;
    ram[16'h0040] = 8'h3C;
    ram[16'h0041] = 8'h77;
    ram[16'h0200] = 8'h00;

    // reset with mem_phi and a CPU request already high: no edge out of reset
    reset = 1'b1;
    cpu_phi = 1'b1; vid_phi = 1'b0; mem_phi = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'h00;
    bus.vid_req = 1'b0; bus.vid_addr = 16'h0000;
    step(); step(); step();
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_ack", bus.cpu_ack, 0);
    check("rst_vid_ack", bus.vid_ack, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_vid_rdata", bus.vid_rdata, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;
    clr_counts();
    step(); step(); step(); step();
    check("no_edge_after_rst", en_cnt, 0);
    mem_phi = 1'b0;
    step();

    // CPU read of 0x1234
    clr_counts();
    mem_phi = 1'b1;
    step();
    check("rd_mem_en", bus.mem_en, 1);
    check("rd_mem_addr", bus.mem_addr, 16'h1234);
    check("rd_mem_we", bus.mem_we, 0);
    mem_phi = 1'b0;
    step();
    check("rd_en_one_cycle", bus.mem_en, 0);
    check("rd_no_early_ack", bus.cpu_ack, 0);
    step();
    check("rd_cpu_ack", bus.cpu_ack, 1);
    check("rd_cpu_rdata", bus.cpu_rdata, 8'hA5);
    check("rd_no_vid_ack", bus.vid_ack, 0);
    bus.cpu_req = 1'b0;
    step();
    check("rd_ack_one_cycle", bus.cpu_ack, 0);
    check("rd_rdata_held", bus.cpu_rdata, 8'hA5);
    check("rd_en_count", en_cnt, 1);

    // CPU write of 0x5A to 0x0200
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0200; bus.cpu_wdata = 8'h5A;
    mem_phi = 1'b1;
    step();
    check("wr_mem_en", bus.mem_en, 1);
    check("wr_mem_we", bus.mem_we, 1);
    check("wr_mem_addr", bus.mem_addr, 16'h0200);
    check("wr_mem_wdata", bus.mem_wdata, 8'h5A);
    mem_phi = 1'b0;
    step();
    check("wr_we_off", bus.mem_we, 0);
    step();
    check("wr_cpu_ack", bus.cpu_ack, 1);
    check("wr_rdata_unchanged", bus.cpu_rdata, 8'hA5);
    bus.cpu_req = 1'b0;
    step();
    check("wr_addr_held", bus.mem_addr, 16'h0200);
    check("wr_wdata_held", bus.mem_wdata, 8'h5A);
    check("wr_ram", ram[16'h0200], 8'h5A);

    // alternation: two slots per phase half-period, both requests held high
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234; bus.cpu_req = 1'b1;
    bus.vid_addr = 16'h0040; bus.vid_req = 1'b1;
    clr_counts();
    for (int half = 0; half < 4; half++) begin
      cpu_phi = (half % 2 == 0);
      vid_phi = (half % 2 != 0);
      for (int s = 0; s < 2; s++) begin
        mem_phi = 1'b1;
        step();
        mem_phi = 1'b0;
        step();
        step();
        check($sformatf("alt_cpu_ack_h%0d_s%0d", half, s), bus.cpu_ack, (half % 2 == 0));
        check($sformatf("alt_vid_ack_h%0d_s%0d", half, s), bus.vid_ack, (half % 2 != 0));
        step();
      end
    end
    check("alt_cpu_acks", cpu_ack_cnt, 4);
    check("alt_vid_acks", vid_ack_cnt, 4);
    check("alt_never_both", both_ack_cnt, 0);
    check("alt_vid_rdata", bus.vid_rdata, 8'h3C);

    // late video request; CPU request held but CPU does not own these slots
    bus.vid_req = 1'b0; bus.vid_addr = 16'h0041;
    bus.cpu_req = 1'b1;
    cpu_phi = 1'b0; vid_phi = 1'b1;
    clr_counts();
    mem_phi = 1'b1;
    step();
    check("late_no_en", bus.mem_en, 0);
    mem_phi = 1'b0;
    step();
    bus.vid_req = 1'b1;
    step(); step();
    check("late_wasted_slot", en_cnt, 0);
    mem_phi = 1'b1;
    step();
    check("late_mem_en", bus.mem_en, 1);
    check("late_mem_addr", bus.mem_addr, 16'h0041);
    mem_phi = 1'b0;
    step(); step();
    check("late_vid_ack", bus.vid_ack, 1);
    check("late_vid_rdata", bus.vid_rdata, 8'h77);
    bus.vid_req = 1'b0;
    step();
    check("nonowner_ignored", cpu_ack_cnt, 0);

    // reset during the mem_en cycle
    cpu_phi = 1'b1; vid_phi = 1'b0;
    bus.cpu_addr = 16'h1234; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    clr_counts();
    mem_phi = 1'b1;
    step();
    check("rsti_mem_en", bus.mem_en, 1);
    reset = 1'b1;
    mem_phi = 1'b0;
    step();
    check("rsti_mem_en_off", bus.mem_en, 0);
    check("rsti_mem_addr", bus.mem_addr, 0);
    check("rsti_cpu_rdata", bus.cpu_rdata, 0);
    check("rsti_vid_rdata", bus.vid_rdata, 0);
    check("rsti_state", state_dbg, 0);
    reset = 1'b0;
    step(); step(); step();
    check("rsti_no_ack", cpu_ack_cnt, 0);
    check("rsti_single_en", en_cnt, 1);
    mem_phi = 1'b1;
    step();
    check("rsti_retry_en", bus.mem_en, 1);
    mem_phi = 1'b0;
    step(); step();
    check("rsti_retry_ack", bus.cpu_ack, 1);
    check("rsti_retry_rdata", bus.cpu_rdata, 8'hA5);
    bus.cpu_req = 1'b0;
    step();

    // phase error: both phases high at slot_start
    cpu_phi = 1'b1; vid_phi = 1'b1;
    bus.cpu_req = 1'b1; bus.vid_req = 1'b1;
    clr_counts();
    mem_phi = 1'b1;
    step();
    mem_phi = 1'b0;
    step(); step(); step();
    check("perr_no_en", en_cnt, 0);
    check("perr_no_ack", cpu_ack_cnt + vid_ack_cnt, 0);
`ifdef MEM_SLOT_STATS_EN
    check("perr_missed", missed_slots, 1);
`endif

    // overrun: second edge two cycles after a served slot
    cpu_phi = 1'b1; vid_phi = 1'b0;
    bus.vid_req = 1'b0;
    bus.cpu_addr = 16'h0200;
    clr_counts();
    mem_phi = 1'b1;
    step();
    check("ovr_mem_en", bus.mem_en, 1);
    mem_phi = 1'b0;
    step();
    mem_phi = 1'b1;
    step();
    check("ovr_first_ack", bus.cpu_ack, 1);
    check("ovr_first_rdata", bus.cpu_rdata, 8'h5A);
    step();
    check("ovr_dropped_no_en", bus.mem_en, 0);
    mem_phi = 1'b0;
    step(); step(); step();
    check("ovr_en_count", en_cnt, 1);
    check("ovr_ack_count", cpu_ack_cnt, 1);
`ifdef MEM_SLOT_STATS_EN
    check("ovr_missed", missed_slots, 2);
    check("stats_cpu_slots", cpu_slots, 2);
    check("stats_vid_slots", vid_slots, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_slot_arbiter.md
# mem_slot_arbiter

Memory-slot arbiter downstream of the clock divider. It turns the divider's cpu_phi / mem_phi / vid_phi phase levels into time-multiplexed accesses to the shared 64 KiB byte-wide RAM. Each rising edge of mem_phi opens one memory slot, owned by either the CPU or the video fetcher. The owner's pending request is issued to the RAM and completed with a one-cycle ack.

## Interface
Parameters:
- ADDR_W, 16, address width for the CPU, video and RAM ports
- DATA_W, 8, data width

Ports:
- CLOCK_50  in  1  system clock; phi inputs are registered levels in this domain
- reset  in  1  synchronous, active-high
- cpu_phi  in  1  CPU phase level from the divider
- mem_phi  in  1  memory phase level; each rising edge opens a slot
- vid_phi  in  1  video phase level
- cpu_req  in  1  CPU request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data; valid in the cpu_ack cycle, held until the next CPU read completes
- cpu_ack  out  1  one-cycle completion pulse
- vid_req  in  1  video read request; held until vid_ack
- vid_addr  in  ADDR_W  video address
- vid_rdata  out  DATA_W  read data; valid in the vid_ack cycle, held until the next video read completes
- vid_ack  out  1  one-cycle completion pulse
- mem_en  out  1  RAM access strobe, one cycle per access
- mem_we  out  1  RAM write enable; qualified by mem_en
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; valid exactly 1 cycle after a read mem_en

## Operation
- Slot edge: slot_start = mem_phi & ~mem_phi_q, where mem_phi_q is mem_phi registered. mem_phi_q resets to 1, so a high mem_phi out of reset is not treated as an edge.
- Owner at slot_start:
  - cpu_phi=1, vid_phi=0: CPU
  - cpu_phi=0, vid_phi=1: video
  - any other combination: no owner; the slot is idle and counted as a phase error
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE→ISSUE: slot_start and the owner's req is high. Latch owner, address, we and wdata (we=0 for video).
  - IDLE→IDLE: slot_start with the owner's req low. The slot is wasted; a request raised later in the same slot waits for the next owned slot.
  - ISSUE→WAIT: mem_en=1 for this cycle only; mem_we, mem_addr and mem_wdata are driven from the latched values.
  - WAIT→DONE: on reads, capture mem_rdata into the owner's rdata register.
  - DONE→IDLE: assert the owner's ack for exactly this cycle.
- The non-owner's req is ignored, however long it is held.
- Overrun: slot_start while not in IDLE drops that slot (no access) and counts as overrun. The current transaction completes normally.
- mem_addr and mem_wdata hold their last values when mem_en=0. mem_we=0 whenever mem_en=0.

## Timing
- Reset values: cpu_ack=0, vid_ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, vid_rdata=0; FSM=IDLE; mem_phi_q=1.
- Latency: slot_start in cycle E → mem_en in E+1 → rdata captured at the end of E+2 → ack in E+3. The block is busy for 3 cycles after the edge.
- Minimum slot_start spacing without overrun is 4 cycles; the divider guarantees at least that.
- Reset mid-transaction: return to IDLE with no ack and no further mem_en. The requester keeps req high and is served in its next owned slot.
- Simultaneous reset and slot_start: reset wins; the edge is lost.
- A requester may deassert req in the ack cycle and reassert it on the following cycle.

## Configuration
- MEM_SLOT_STATS_EN defined adds these outputs:
  - cpu_slots [7:0]: served CPU slots
  - vid_slots [7:0]: served video slots
  - missed_slots [7:0]: overruns plus phase errors
  - All three saturate at 255 and reset to 0.
- MEM_SLOT_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- CPU read: hold cpu_phi=1, vid_phi=0, cpu_req=1, cpu_we=0, cpu_addr=0x1234; RAM returns 0xA5 → exactly one mem_en with mem_addr=0x1234 at E+1; cpu_ack at E+3 with cpu_rdata=0xA5; no vid_ack.
- CPU write: cpu_we=1, cpu_wdata=0x5A, addr 0x0200 → mem_en=1, mem_we=1, mem_wdata=0x5A at E+1; cpu_ack at E+3.
- Alternation: run the real divider with both reqs held high → acks alternate by cpu_phi level: two CPU slots per cpu_phi-high half-period, two video slots per low half-period, and never both acks in one cycle.
- Late request: raise vid_req two cycles after a video slot_start → no access in that slot; served in the next video-owned slot.
- Reset in ISSUE: assert reset during the mem_en cycle → no ack; all outputs return to 0 on the next cycle; the request completes in its next owned slot.
- Phase error / overrun (MEM_SLOT_STATS_EN defined): force cpu_phi=vid_phi=1 at slot_start → no mem_en, missed_slots +1. Then force a mem_phi edge 2 cycles after a served slot → the slot is dropped, missed_slots +1 again, and the first transaction still acks.
